// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, screen geometry and the
// vertical limits derived from it, plus the bird motion register bundle.
package game_pkg;

  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned LAND_HEIGHT = 100;
  localparam int unsigned BIRD_H      = 24;
  localparam int unsigned BIRD_W      = 34;
  localparam int unsigned BIRD_HPOS   = 320;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned VPOS_W  = 9;
  localparam int unsigned VEL_W   = 8;
  localparam int unsigned FRAME_W = 2;
  // Wide enough that vpos + velocity never wraps before clamping.
  localparam int unsigned CALC_W  = 11;

  localparam int unsigned GROUND_Y_DEF = LAND_HEIGHT + BIRD_H / 2;
  localparam int unsigned CEIL_Y_DEF   = SCREEN_H - 1 - BIRD_H / 2;

  typedef enum logic [STATE_W-1:0] {
    ST_READY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_e;

  typedef struct packed {
    logic [VPOS_W-1:0]  vpos;
    logic [VEL_W-1:0]   vel;
    logic [FRAME_W-1:0] frame;
    logic               hit_ground;
    logic               hit_ceiling;
  } bird_state_t;

  // Encoding 3 is not a real state; it behaves as OVER.
  function automatic game_state_e decode_state(input logic [STATE_W-1:0] s);
    case (s)
      2'd0:    return ST_READY;
      2'd1:    return ST_PLAY;
      default: return ST_OVER;
    endcase
  endfunction

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector: remembers the previous level and flags a 0->1 change
// in the same cycle it appears. Edges seen while in reset are suppressed.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  output logic o_pulse_c
);

  logic r_prev;

  // Tracks the level even during reset so a button held through reset
  // does not look like a fresh press afterwards.
  always_ff @(posedge clk) begin
    r_prev <= i_level;
  end

  assign o_pulse_c = i_level & ~r_prev & ~rst;

endmodule

// File: rtl/bird_motion.sv
// Bird vertical physics and wing animation, advanced once per physics tick.
// Drives bird position/frame for display and ground/ceiling contact flags.
module bird_motion
  import game_pkg::*;
#(
  parameter int unsigned START_POS  = 240,
  parameter int unsigned FLAP_VEL   = 6,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned MAX_FALL   = 8,
  parameter int unsigned GROUND_Y   = GROUND_Y_DEF,
  parameter int unsigned CEIL_Y     = CEIL_Y_DEF,
  parameter int unsigned ANIM_TICKS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [STATE_W-1:0] state,
  input  logic               flap,
  output logic [VPOS_W-1:0]  bird_vpos,
  output logic [FRAME_W-1:0] bird_frame,
  output logic [VEL_W-1:0]   bird_vel,
  output logic               hit_ground,
  output logic               hit_ceiling
);

  localparam int unsigned CNT_W = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;

  localparam logic signed [CALC_W-1:0] C_FLAP    = CALC_W'(FLAP_VEL);
  localparam logic signed [CALC_W-1:0] C_GRAVITY = CALC_W'(GRAVITY);
  localparam logic signed [CALC_W-1:0] C_MIN_VEL = CALC_W'(0) - CALC_W'(MAX_FALL);
  localparam logic signed [CALC_W-1:0] C_GROUND  = CALC_W'(GROUND_Y);
  localparam logic signed [CALC_W-1:0] C_CEIL    = CALC_W'(CEIL_Y);
  localparam logic [CNT_W-1:0]         C_CNT_TOP = CNT_W'(ANIM_TICKS - 1);

  game_state_e w_state;
  game_state_e r_state_q;
  logic        w_state_chg;

  logic w_flap_edge;
  logic w_flap_now;
  logic r_flap_pend;
  logic w_flap_pend_nxt;

  bird_state_t r_bird;
  bird_state_t w_bird_nxt;
  logic [CNT_W-1:0] r_anim_cnt;
  logic [CNT_W-1:0] w_anim_cnt_base;
  logic [CNT_W-1:0] w_anim_cnt_nxt;
  logic             w_anim_en;

  logic signed [CALC_W-1:0] w_vel_ext;
  logic signed [CALC_W-1:0] w_vel_grav;
  logic signed [CALC_W-1:0] w_vel_cand;
  logic signed [CALC_W-1:0] w_pos_next;

  rise_edge u_flap_edge (
    .clk       (clk),
    .rst       (rst),
    .i_level   (flap),
    .o_pulse_c (w_flap_edge)
  );

  assign w_state     = decode_state(state);
  assign w_state_chg = (w_state != r_state_q);

  // A press landing on the tick cycle is honoured by that tick.
  assign w_flap_now      = r_flap_pend | w_flap_edge;
  assign w_flap_pend_nxt = tick ? 1'b0 : w_flap_now;

  assign w_vel_ext  = CALC_W'(signed'(r_bird.vel));
  assign w_vel_grav = w_vel_ext - C_GRAVITY;
  assign w_vel_cand = w_flap_now ? C_FLAP
                    : ((w_vel_grav < C_MIN_VEL) ? C_MIN_VEL : w_vel_grav);
  assign w_pos_next = signed'({2'b00, r_bird.vpos}) + w_vel_cand;

  assign w_anim_cnt_base = w_state_chg ? '0 : r_anim_cnt;

  // Next-state for physics and animation; only ticks move the bird.
  always_comb begin
    w_bird_nxt             = r_bird;
    w_bird_nxt.hit_ceiling = 1'b0;
    w_anim_cnt_nxt         = w_anim_cnt_base;
    w_anim_en              = 1'b0;

    if (tick) begin
      case (w_state)
        ST_READY: begin
          w_bird_nxt.vpos       = VPOS_W'(START_POS);
          w_bird_nxt.vel        = '0;
          w_bird_nxt.hit_ground = 1'b0;
          w_anim_en             = 1'b1;
        end
        ST_PLAY: begin
          if (!r_bird.hit_ground) begin
            w_anim_en = 1'b1;
            if (w_pos_next <= C_GROUND) begin
              w_bird_nxt.vpos       = VPOS_W'(GROUND_Y);
              w_bird_nxt.vel        = '0;
              w_bird_nxt.hit_ground = 1'b1;
            end else if (w_pos_next >= C_CEIL) begin
              w_bird_nxt.vpos        = VPOS_W'(CEIL_Y);
              w_bird_nxt.vel         = '0;
              w_bird_nxt.hit_ceiling = 1'b1;
            end else begin
              w_bird_nxt.vpos = VPOS_W'(w_pos_next);
              w_bird_nxt.vel  = VEL_W'(w_vel_cand);
            end
          end
        end
        default: ;
      endcase
    end

    if (w_anim_en) begin
      if (w_anim_cnt_base == C_CNT_TOP) begin
        w_anim_cnt_nxt   = '0;
        w_bird_nxt.frame = (r_bird.frame == FRAME_W'(2)) ? '0
                         : r_bird.frame + FRAME_W'(1);
      end else begin
        w_anim_cnt_nxt = w_anim_cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    r_state_q <= w_state;
    if (rst) begin
      r_bird.vpos        <= VPOS_W'(START_POS);
      r_bird.vel         <= '0;
      r_bird.frame       <= '0;
      r_bird.hit_ground  <= 1'b0;
      r_bird.hit_ceiling <= 1'b0;
      r_anim_cnt         <= '0;
      r_flap_pend        <= 1'b0;
    end else begin
      r_bird      <= w_bird_nxt;
      r_anim_cnt  <= w_anim_cnt_nxt;
      r_flap_pend <= w_flap_pend_nxt;
    end
  end

  assign bird_vpos   = r_bird.vpos;
  assign bird_vel    = r_bird.vel;
  assign bird_frame  = r_bird.frame;
  assign hit_ground  = r_bird.hit_ground;
  assign hit_ceiling = r_bird.hit_ceiling;

endmodule
